// File: rtl/apu_req_arbiter.sv
// Round-robin sharing of one APU among NB_CORES cores.
// One-entry request slot towards the unit, registered tag-routed response back.
module apu_req_arbiter #(
  parameter int NB_CORES = 4,
  parameter int WARG     = 32,
  parameter int NARGS    = 3,
  parameter int WOP      = 6,
  parameter int NDSFLAGS = 15,
  parameter int WRESULT  = 32,
  parameter int NUSFLAGS = 8,
  parameter int WTAG     = $clog2(NB_CORES)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,

  input  logic [NB_CORES-1:0]         core_req_i,
  input  logic [NB_CORES*WOP-1:0]     core_op_i,
  input  logic [NB_CORES*NARGS*WARG-1:0] core_args_i,
  input  logic [NB_CORES*NDSFLAGS-1:0] core_flags_i,
  output logic [NB_CORES-1:0]         core_gnt_o,

  output logic                        apu_req_o,
  output logic [WOP-1:0]              apu_op_o,
  output logic [NARGS*WARG-1:0]       apu_args_o,
  output logic [NDSFLAGS-1:0]         apu_flags_o,
  output logic [WTAG-1:0]             apu_tag_o,
  input  logic                        apu_gnt_i,

  input  logic                        apu_rvalid_i,
  input  logic [WTAG-1:0]             apu_rtag_i,
  input  logic [WRESULT-1:0]          apu_result_i,
  input  logic [NUSFLAGS-1:0]         apu_rflags_i,

  output logic [NB_CORES-1:0]         core_rvalid_o,
  output logic [WRESULT-1:0]          core_result_o,
  output logic [NUSFLAGS-1:0]         core_rflags_o,
  output logic                        tag_err_o
);

  localparam int PW = $clog2(NB_CORES);
  localparam int WA = NARGS * WARG;

  logic                slot_full_q;
  logic [WOP-1:0]      op_q;
  logic [WA-1:0]       args_q;
  logic [NDSFLAGS-1:0] flags_q;
  logic [WTAG-1:0]     tag_q;
  logic [PW-1:0]       ptr_q;

  logic                slot_free;
  logic                found;
  logic                grant;
  logic [PW-1:0]       idx;
  logic [PW-1:0]       sel;
  logic [PW-1:0]       ptr_nxt;

  logic [WOP-1:0]      sel_op;
  logic [WA-1:0]       sel_args;
  logic [NDSFLAGS-1:0] sel_flags;

  logic [NB_CORES-1:0] rvalid_d;
  logic                tag_ok;

  // A full slot is also free when the unit takes it this very cycle
  assign slot_free = !slot_full_q || apu_gnt_i;

  // Scan upward from the pointer, wrapping; first requester wins
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NB_CORES; i++) begin
      idx = PW'((int'(ptr_q) + i) % NB_CORES);
      if (!found && core_req_i[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  assign grant = found && slot_free && !rst_i;

  always_comb begin
    core_gnt_o = '0;
    if (grant) core_gnt_o[sel] = 1'b1;
  end

  assign ptr_nxt = (int'(sel) == NB_CORES - 1) ? '0 : sel + 1'b1;

  always_comb begin
    sel_op    = '0;
    sel_args  = '0;
    sel_flags = '0;
    for (int i = 0; i < NB_CORES; i++) begin
      if (sel == PW'(i)) begin
        sel_op    = core_op_i[i*WOP +: WOP];
        sel_args  = core_args_i[i*WA +: WA];
        sel_flags = core_flags_i[i*NDSFLAGS +: NDSFLAGS];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_full_q <= 1'b0;
      op_q        <= '0;
      args_q      <= '0;
      flags_q     <= '0;
      tag_q       <= '0;
      ptr_q       <= '0;
    end else begin
      if (grant) begin
        slot_full_q <= 1'b1;
        op_q        <= sel_op;
        args_q      <= sel_args;
        flags_q     <= sel_flags;
        tag_q       <= WTAG'(sel);
        ptr_q       <= ptr_nxt;
      end else if (apu_gnt_i) begin
        slot_full_q <= 1'b0;
      end
    end
  end

  assign apu_req_o   = slot_full_q;
  assign apu_op_o    = op_q;
  assign apu_args_o  = args_q;
  assign apu_flags_o = flags_q;
  assign apu_tag_o   = tag_q;

  // Response routing; tags beyond the core count are dropped and flagged
  assign tag_ok = int'(apu_rtag_i) < NB_CORES;

  always_comb begin
    rvalid_d = '0;
    for (int i = 0; i < NB_CORES; i++) begin
      rvalid_d[i] = apu_rvalid_i && (int'(apu_rtag_i) == i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      core_rvalid_o <= '0;
      core_result_o <= '0;
      core_rflags_o <= '0;
      tag_err_o     <= 1'b0;
    end else begin
      core_rvalid_o <= rvalid_d;
      if (apu_rvalid_i) begin
        core_result_o <= apu_result_i;
        core_rflags_o <= apu_rflags_i;
        if (!tag_ok) tag_err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apu_req_arbiter.sv
// Bench for apu_req_arbiter: directed scenarios plus randomized
// traffic against a cycle-level reference model.
module tb_apu_req_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  core_req;
  logic [23:0] core_op;
  logic [383:0] core_args;
  logic [59:0] core_flags;
  logic [3:0]  core_gnt;
  logic        apu_req;
  logic [5:0]  apu_op;
  logic [95:0] apu_args;
  logic [14:0] apu_flags;
  logic [1:0]  apu_tag;
  logic        apu_gnt;
  logic        apu_rvalid;
  logic [1:0]  apu_rtag;
  logic [31:0] apu_result;
  logic [7:0]  apu_rflags;
  logic [3:0]  core_rvalid;
  logic [31:0] core_result;
  logic [7:0]  core_rflags;
  logic        tag_err;

  apu_req_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .core_req_i(core_req), .core_op_i(core_op),
    .core_args_i(core_args), .core_flags_i(core_flags),
    .core_gnt_o(core_gnt),
    .apu_req_o(apu_req), .apu_op_o(apu_op), .apu_args_o(apu_args),
    .apu_flags_o(apu_flags), .apu_tag_o(apu_tag), .apu_gnt_i(apu_gnt),
    .apu_rvalid_i(apu_rvalid), .apu_rtag_i(apu_rtag),
    .apu_result_i(apu_result), .apu_rflags_i(apu_rflags),
    .core_rvalid_o(core_rvalid), .core_result_o(core_result),
    .core_rflags_o(core_rflags), .tag_err_o(tag_err)
  );

  // Three-core instance for the illegal-tag scenario
  logic        rst3;
  logic [2:0]  req3;
  logic [17:0] op3;
  logic [287:0] args3;
  logic [44:0] flags3;
  logic [2:0]  gnt3;
  logic        areq3;
  logic [5:0]  aop3;
  logic [95:0] aargs3;
  logic [14:0] aflags3;
  logic [1:0]  atag3;
  logic        agnt3;
  logic        rvalid3;
  logic [1:0]  rtag3;
  logic [31:0] result3;
  logic [7:0]  rflags3;
  logic [2:0]  crvalid3;
  logic [31:0] cresult3;
  logic [7:0]  crflags3;
  logic        tag_err3;

  apu_req_arbiter #(.NB_CORES(3)) dut3 (
    .clk_i(clk), .rst_i(rst3),
    .core_req_i(req3), .core_op_i(op3),
    .core_args_i(args3), .core_flags_i(flags3),
    .core_gnt_o(gnt3),
    .apu_req_o(areq3), .apu_op_o(aop3), .apu_args_o(aargs3),
    .apu_flags_o(aflags3), .apu_tag_o(atag3), .apu_gnt_i(agnt3),
    .apu_rvalid_i(rvalid3), .apu_rtag_i(rtag3),
    .apu_result_i(result3), .apu_rflags_i(rflags3),
    .core_rvalid_o(crvalid3), .core_result_o(cresult3),
    .core_rflags_o(crflags3), .tag_err_o(tag_err3)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state (post-edge view of the 4-core DUT)
  int          m_p;
  bit          m_full;
  logic [5:0]  m_op;
  logic [95:0] m_args;
  logic [14:0] m_flags;
  int          m_tag;
  logic [3:0]  m_rv;
  logic [31:0] m_res;
  logic [7:0]  m_rf;
  bit          m_err;

  function automatic int model_winner();
    int w;
    w = -1;
    if (!rst && !(m_full && !apu_gnt)) begin
      for (int i = 0; i < 4; i++) begin
        if (w < 0 && core_req[(m_p + i) % 4]) w = (m_p + i) % 4;
      end
    end
    return w;
  endfunction

  function automatic logic [3:0] model_gnt();
    int w;
    logic [3:0] g;
    w = model_winner();
    g = '0;
    if (w >= 0) g[w] = 1'b1;
    return g;
  endfunction

  function automatic void model_update();
    int w;
    w = model_winner();
    if (rst) begin
      m_p = 0; m_full = 0; m_op = '0; m_args = '0; m_flags = '0;
      m_tag = 0; m_rv = '0; m_res = '0; m_rf = '0; m_err = 0;
    end else begin
      if (m_full && apu_gnt) m_full = 0;
      if (w >= 0) begin
        m_full  = 1;
        m_op    = core_op[w*6 +: 6];
        m_args  = core_args[w*96 +: 96];
        m_flags = core_flags[w*15 +: 15];
        m_tag   = w;
        m_p     = (w + 1) % 4;
      end
      m_rv = '0;
      if (apu_rvalid) begin
        if (apu_rtag < 4) m_rv[apu_rtag] = 1'b1;
        else m_err = 1;
        m_res = apu_result;
        m_rf  = apu_rflags;
      end
    end
  endfunction

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; core_req = 4'hF; apu_gnt = 0;
    #1;
    checks++;
    if (core_gnt !== 4'b0000) begin
      errors++; $display("FAIL rst_gnt: got %b want 0000", core_gnt);
    end
    tick();
    checks++;
    if (apu_req !== 1'b0 || apu_op !== 6'd0 || apu_tag !== 2'd0 ||
        apu_args !== 96'd0 || apu_flags !== 15'd0) begin
      errors++; $display("FAIL rst_slot: req=%b op=%h tag=%0d want all 0",
                         apu_req, apu_op, apu_tag);
    end
    checks++;
    if (core_rvalid !== 4'd0 || core_result !== 32'd0 ||
        core_rflags !== 8'd0 || tag_err !== 1'b0) begin
      errors++; $display("FAIL rst_resp: rv=%b res=%h rf=%h err=%b want 0",
                         core_rvalid, core_result, core_rflags, tag_err);
    end
    core_req = 4'h0;
  endtask

  task automatic test_rr_all();
    logic [3:0] want;
    rst = 0; core_req = 4'hF; apu_gnt = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      want = 4'b0001 << (i % 4);
      checks++;
      if (core_gnt !== want) begin
        errors++; $display("FAIL rr_gnt%0d: got %b want %b", i, core_gnt, want);
      end
      if (i > 0) begin
        checks++;
        if (apu_req !== 1'b1 || apu_tag !== 2'((i - 1) % 4)) begin
          errors++; $display("FAIL rr_tag%0d: req=%b tag=%0d want 1/%0d",
                             i, apu_req, apu_tag, (i - 1) % 4);
        end
      end
      tick();
    end
    checks++;
    if (apu_tag !== 2'd0) begin
      errors++; $display("FAIL rr_tag_last: got %0d want 0", apu_tag);
    end
    core_req = 4'h0;
    tick();
    checks++;
    if (apu_req !== 1'b0) begin
      errors++; $display("FAIL rr_drain: req=%b want 0", apu_req);
    end
  endtask

  task automatic test_hold();
    core_req = 4'b0100; apu_gnt = 0;
    core_op[2*6 +: 6] = 6'h05;
    core_args[2*96 +: 96] = {32'd1, 32'd2, 32'd3};
    #1;
    checks++;
    if (core_gnt !== 4'b0100) begin
      errors++; $display("FAIL hold_gnt: got %b want 0100", core_gnt);
    end
    tick();
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin apu_gnt = 1; core_req = 4'h0; end
      #1;
      checks++;
      if (apu_req !== 1'b1 || apu_op !== 6'h05 || apu_tag !== 2'd2 ||
          apu_args !== {32'd1, 32'd2, 32'd3} || core_gnt !== 4'b0000) begin
        errors++;
        $display("FAIL hold_cyc%0d: req=%b op=%h tag=%0d args=%h gnt=%b", c,
                 apu_req, apu_op, apu_tag, apu_args, core_gnt);
      end
      tick();
    end
    checks++;
    if (apu_req !== 1'b0) begin
      errors++; $display("FAIL hold_release: req=%b want 0", apu_req);
    end
  endtask

  task automatic test_rr_skip();
    core_req = 4'b0101; apu_gnt = 1;
    #1;
    checks++;
    if (core_gnt !== 4'b0001) begin
      errors++; $display("FAIL skip_wrap: got %b want 0001", core_gnt);
    end
    tick();
    #1;
    checks++;
    if (core_gnt !== 4'b0100) begin
      errors++; $display("FAIL skip_next: got %b want 0100", core_gnt);
    end
    tick();
    core_req = 4'h0;
    tick();
  endtask

  task automatic test_response();
    core_req = 4'b0001; apu_gnt = 0;
    apu_rvalid = 1; apu_rtag = 2'd1;
    apu_result = 32'hDEADBEEF; apu_rflags = 8'hA5;
    #1;
    checks++;
    if (core_gnt !== 4'b0001) begin
      errors++; $display("FAIL resp_gnt: got %b want 0001", core_gnt);
    end
    tick();
    apu_rvalid = 0; core_req = 4'h0; apu_result = 32'h12345678;
    #1;
    checks++;
    if (core_rvalid !== 4'b0010 || core_result !== 32'hDEADBEEF ||
        core_rflags !== 8'hA5) begin
      errors++; $display("FAIL resp_route: rv=%b res=%h rf=%h want 0010/deadbeef/a5",
                         core_rvalid, core_result, core_rflags);
    end
    checks++;
    if (apu_req !== 1'b1 || apu_tag !== 2'd0) begin
      errors++; $display("FAIL resp_issue: req=%b tag=%0d want 1/0", apu_req, apu_tag);
    end
    tick();
    checks++;
    if (core_rvalid !== 4'b0000 || core_result !== 32'hDEADBEEF) begin
      errors++; $display("FAIL resp_hold: rv=%b res=%h want 0000/deadbeef",
                         core_rvalid, core_result);
    end
    apu_gnt = 1;
    tick();
  endtask

  task automatic test_tag_err();
    rst3 = 1;
    tick();
    rst3 = 0;
    checks++;
    if (tag_err3 !== 1'b0) begin
      errors++; $display("FAIL tagerr_init: got %b want 0", tag_err3);
    end
    rvalid3 = 1; rtag3 = 2'd3; result3 = 32'hCAFE0001;
    tick();
    rvalid3 = 0;
    checks++;
    if (crvalid3 !== 3'b000 || tag_err3 !== 1'b1) begin
      errors++; $display("FAIL tagerr_set: rv=%b err=%b want 000/1", crvalid3, tag_err3);
    end
    repeat (10) tick();
    checks++;
    if (tag_err3 !== 1'b1) begin
      errors++; $display("FAIL tagerr_sticky: got %b want 1", tag_err3);
    end
  endtask

  task automatic test_reset_pending();
    core_req = 4'b0010; apu_gnt = 0;
    #1;
    checks++;
    if (core_gnt !== 4'b0010) begin
      errors++; $display("FAIL rstp_gnt: got %b want 0010", core_gnt);
    end
    tick();
    rst = 1; core_req = 4'hF;
    #1;
    checks++;
    if (core_gnt !== 4'b0000 || apu_req !== 1'b1) begin
      errors++; $display("FAIL rstp_during: gnt=%b req=%b want 0000/1", core_gnt, apu_req);
    end
    tick();
    rst = 0;
    #1;
    checks++;
    if (apu_req !== 1'b0) begin
      errors++; $display("FAIL rstp_cleared: req=%b want 0", apu_req);
    end
    checks++;
    if (core_gnt !== 4'b0001) begin
      errors++; $display("FAIL rstp_ptr: gnt=%b want 0001", core_gnt);
    end
    tick();
    core_req = 4'h0; apu_gnt = 1;
    tick();
  endtask

  task automatic test_random();
    logic [3:0] want;
    rst = 1;
    tick();
    rst = 0;
    for (int n = 0; n < 400; n++) begin
      rst        = ($urandom_range(0, 59) == 0);
      core_req   = 4'($urandom);
      core_op    = {$urandom, $urandom}[23:0];
      for (int k = 0; k < 12; k++) core_args[k*32 +: 32] = $urandom;
      core_flags = {$urandom, $urandom}[59:0];
      apu_gnt    = ($urandom_range(0, 2) != 0);
      apu_rvalid = $urandom_range(0, 1) == 1;
      apu_rtag   = 2'($urandom);
      apu_result = $urandom;
      apu_rflags = 8'($urandom);
      #1;
      want = model_gnt();
      checks++;
      if (core_gnt !== want) begin
        errors++; $display("FAIL rnd_gnt@%0d: got %b want %b", n, core_gnt, want);
      end
      tick();
      checks++;
      if (apu_req !== m_full || apu_tag !== 2'(m_tag) || apu_op !== m_op ||
          apu_args !== m_args || apu_flags !== m_flags) begin
        errors++;
        $display("FAIL rnd_slot@%0d: req=%b tag=%0d op=%h want %b/%0d/%h",
                 n, apu_req, apu_tag, apu_op, m_full, m_tag, m_op);
      end
      checks++;
      if (core_rvalid !== m_rv || core_result !== m_res ||
          core_rflags !== m_rf || tag_err !== m_err) begin
        errors++;
        $display("FAIL rnd_resp@%0d: rv=%b res=%h rf=%h err=%b want %b/%h/%h/%b",
                 n, core_rvalid, core_result, core_rflags, tag_err,
                 m_rv, m_res, m_rf, m_err);
      end
    end
    rst = 0;
  endtask

  initial begin
    rst = 1; core_req = '0; core_op = '0; core_args = '0; core_flags = '0;
    apu_gnt = 0; apu_rvalid = 0; apu_rtag = '0; apu_result = '0; apu_rflags = '0;
    rst3 = 1; req3 = '0; op3 = '0; args3 = '0; flags3 = '0; agnt3 = 0;
    rvalid3 = 0; rtag3 = '0; result3 = '0; rflags3 = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_rr_all();
    test_hold();
    test_rr_skip();
    test_response();
    test_tag_err();
    test_reset_pending();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apu_req_arbiter.md
APU_REQ_ARBITER -- requirements
Module: apu_req_arbiter

Interface
REQ-001 Parameters (name, default, meaning); each SHALL be overridable:
- NB_CORES, 4, requesting cores; legal range 2..16.
- WARG, 32, operand width.
- NARGS, 3, operands per request.
- WOP, 6, opcode width.
- NDSFLAGS, 15, downstream flag width.
- WRESULT, 32, result width.
- NUSFLAGS, 8, upstream flag width.
- WTAG, $clog2(NB_CORES), tag width.
REQ-002 Ports (name, direction, width, meaning):
- clk_i, in, 1, single clock.
- rst_i, in, 1, synchronous, active-high reset.
- core_req_i, in, NB_CORES, per-core request.
- core_op_i, in, NB_CORES*WOP, per-core opcode; core k in slice k.
- core_args_i, in, NB_CORES*NARGS*WARG, per-core operands.
- core_flags_i, in, NB_CORES*NDSFLAGS, per-core flags.
- core_gnt_o, out, NB_CORES, per-core grant.
- apu_req_o, out, 1, request to the shared unit.
- apu_op_o, out, WOP, opcode.
- apu_args_o, out, NARGS*WARG, operands.
- apu_flags_o, out, NDSFLAGS, flags.
- apu_tag_o, out, WTAG, originating core index.
- apu_gnt_i, in, 1, unit accepts the request.
- apu_rvalid_i, in, 1, result valid.
- apu_rtag_i, in, WTAG, result tag.
- apu_result_i, in, WRESULT, result.
- apu_rflags_i, in, NUSFLAGS, result flags.
- core_rvalid_o, out, NB_CORES, per-core result valid.
- core_result_o, out, WRESULT, result, shared by all cores.
- core_rflags_o, out, NUSFLAGS, result flags, shared by all cores.
- tag_err_o, out, 1, sticky flag: a result arrived with an illegal tag.

Function
REQ-003 Request path SHALL be a one-entry register (slot) driving apu_req_o/op/args/flags/tag.
REQ-004 Slot is "free" when empty, or when full with apu_req_o && apu_gnt_i in the same cycle.
REQ-005 When the slot is free and any core_req_i is set, the block SHALL select exactly one core k, assert core_gnt_o[k] combinationally in that cycle, and load the payload of core k plus tag k into the slot at the next edge.
REQ-006 core_gnt_o SHALL be all-zero when the slot is not free or when no core requests.
REQ-007 Selection SHALL be round-robin: scan from pointer p upward, wrapping from NB_CORES-1 to 0; the first requesting core wins.
REQ-008 After a grant to core k, p SHALL become (k+1) mod NB_CORES; p SHALL be unchanged in cycles without a grant.
REQ-009 apu_req_o SHALL stay high and the slot contents SHALL stay stable until apu_gnt_i is sampled high.
REQ-010 A grant and an unrelated apu_gnt_i in the same cycle SHALL give back-to-back issue with no bubble.
REQ-011 Response path SHALL be registered with one-cycle latency. In cycle t+1, core_rvalid_o[k] SHALL be 1 iff apu_rvalid_i was high in cycle t and apu_rtag_i == k; core_result_o/core_rflags_o SHALL hold the cycle-t values.
REQ-012 core_result_o/core_rflags_o SHALL update only when apu_rvalid_i is high and SHALL hold their value otherwise.
REQ-013 A response with apu_rtag_i >= NB_CORES SHALL raise no core_rvalid_o and SHALL set tag_err_o, which stays high until reset.
REQ-014 Request and response paths are independent; a response and a grant in the same cycle SHALL both be honoured.

Reset
REQ-015 Synchronous reset (rst_i high at an edge) SHALL give:
- slot empty, apu_req_o=0;
- p=0;
- core_rvalid_o=0, tag_err_o=0;
- apu_op/args/flags/tag, core_result_o, core_rflags_o = 0.
REQ-016 Reset during a pending request SHALL discard the slot with no grant to the unit.
REQ-017 core_gnt_o SHALL be 0 while rst_i is high.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- V1: after reset, cores 0..3 all request continuously, apu_gnt_i=1 -> grants 0,1,2,3,0 on consecutive cycles; apu_tag_o follows one cycle later.
- V2: core 2 requests with op=6'h05, args={1,2,3}, apu_gnt_i=0 for 3 cycles then 1 -> core_gnt_o=4'b0100 once; apu_req_o held 4 cycles with stable payload; no further grant until the slot frees.
- V3: p=3, requests 4'b0101 -> core 0 wins, p=1; next winner is core 2.
- V4: apu_rvalid_i=1, rtag=1, result=32'hDEADBEEF -> next cycle core_rvalid_o=4'b0010, core_result_o=32'hDEADBEEF.
- V5: NB_CORES=3, rtag=3 -> core_rvalid_o=0, tag_err_o=1, still 1 after 10 idle cycles.
- V6: rst_i asserted while apu_req_o=1 and apu_gnt_i=0 -> next cycle apu_req_o=0, p=0; core 0 wins the first post-reset arbitration.
